smac_layer_seq: RTL
===================

# smac_layer_seq

Layer-level sequencer that sits above the SMAC control unit and drives it across a whole convolution layer. It accepts one layer configuration through a valid/ready handshake, holds the programmable counter limits and parallelism selects stable, and gates the core with `core_stall_n`. It reacts to the control unit's `update_in`/`update_out` pulses by running activation-fetch and output-store handshakes with the memory side, and flags completion after the programmed number of output tiles.

## Interface
- `Pa`, 8, activation parallelism; sizes `cfg_max_quant`.
- `Pw`, 8, weight parallelism; sizes `cfg_max_quant`.
- `MNO`, 288, max operations per output; sizes `cfg_max_done`.
- `MNV`, 50176, max input volume; sizes `cfg_max_in_vol`.
- `TW`, 16, tile counter width.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `abort`  in  1  synchronous abort to IDLE.
- `cfg_valid`  in  1  configuration valid.
- `cfg_ready`  out  1  high exactly when in IDLE.
- `cfg_max_done`  in  $clog2(MNO)  done-counter limit.
- `cfg_max_quant`  in  $clog2(Pa*Pw)  quant-counter limit.
- `cfg_max_out`, `cfg_max_relu`, `cfg_max_fil_group`  in  3 each  counter limits.
- `cfg_max_in_vol`  in  $clog2(MNV)  input-volume limit.
- `cfg_par_sel_Pa`  in  1  activation parallelism select.
- `cfg_par_sel_Pw`  in  2  weight parallelism select.
- `cfg_n_tiles`  in  TW  output tiles in the layer.
- `max_val_cnt_done`, `max_val_cnt_quant`, `max_val_cnt_out`, `max_val_cnt_relu`, `max_val_fil_group`, `max_val_in_vol`, `par_sel_Pa`, `par_sel_Pw`  out  same widths as the matching `cfg_*` ports  registered copies sent to the control unit.
- `core_stall_n`  out  1  core run enable.
- `update_in`  in  1  control unit requests new activations (1-cycle pulse).
- `update_out`  in  1  control unit has an output volume ready (1-cycle pulse).
- `act_fetch_req`  out  1  activation fetch request.
- `act_fetch_ack`  in  1  fetch complete.
- `out_store_req`  out  1  output store request.
- `out_store_ack`  in  1  store complete.
- `tile_idx`  out  TW  index of the current tile.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `layer_done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, FETCH, COMPUTE, REFILL, STORE, DONE. All outputs are Moore, decoded from registered state and registers.
- IDLE
  - `cfg_ready`=1.
  - On `cfg_valid`: latch all `cfg_*` into the `max_val_*`/`par_sel_*` registers, latch `cfg_n_tiles`, clear `tile_idx`.
  - Next state is FETCH, or DONE if `cfg_n_tiles`==0.
- FETCH
  - `act_fetch_req`=1.
  - On `act_fetch_ack`: go to COMPUTE.
- COMPUTE
  - `core_stall_n`=1.
  - `update_out` → STORE. This has priority over `update_in`.
  - `update_in` alone → REFILL.
  - Simultaneous `update_in` and `update_out`: go to STORE. The refill is subsumed by the next tile's FETCH, or dropped if the tile was the last.
- REFILL
  - `act_fetch_req`=1.
  - On `act_fetch_ack`: go to COMPUTE.
- STORE
  - `out_store_req`=1.
  - On `out_store_ack`: if `tile_idx`==n_tiles-1, go to DONE; otherwise increment `tile_idx` and go to FETCH.
  - The comparison is made before the increment, so `tile_idx` never wraps.
- DONE: `layer_done`=1 for one cycle, then IDLE.
- `core_stall_n`=0 in every state except COMPUTE.
- Ignored inputs:
  - `update_in`/`update_out` outside COMPUTE.
  - `act_fetch_ack` outside FETCH/REFILL.
  - `out_store_ack` outside STORE.
  - `cfg_valid` outside IDLE.
- Config registers hold their values through IDLE until the next accepted configuration. `abort` does not clear them.
- `abort` (any state) → IDLE next cycle. All requests, `core_stall_n` and `layer_done` drop to 0, and no `layer_done` is issued.

## Timing
- Reset: state IDLE, and every output 0 except `cfg_ready`=1. Config registers, `tile_idx` and `n_tiles` are all 0.
- Config accepted at edge k: `act_fetch_req`=1 and new `max_val_*` visible in cycle k+1.
- Ack sampled at edge a: request low and the next state's outputs valid in cycle a+1. Minimum request width is 1 cycle (ack may arrive in the same cycle the request rises).
- Update pulse at edge e in COMPUTE: `core_stall_n`=0 in cycle e+1. So the core runs at most one cycle past the pulse.
- Last `out_store_ack` at edge s: `layer_done`=1 in cycle s+1, and `cfg_ready`=1 in cycle s+2.
- `cfg_n_tiles`=0 accepted at k: `layer_done` in k+1, IDLE in k+2.
- `rst` asserted mid-operation: all outputs return to reset values immediately (asynchronous), with no waiting on outstanding acks.

## Test plan
- Reset then configure with `n_tiles`=2 and max values 287/63/7/7/7/50175:
  - registers match in the cycle after acceptance;
  - fetch, compute, store, fetch, compute, store;
  - `tile_idx` goes 0→1;
  - exactly one `layer_done`, 1 cycle after the second `out_store_ack`.
- In COMPUTE pulse `update_in` and hold `act_fetch_ack` low for 5 cycles:
  - `core_stall_n`=0 for 6 cycles;
  - `act_fetch_req` stays high;
  - COMPUTE resumes the cycle after the ack.
- `update_in` and `update_out` pulse together with `n_tiles`=1:
  - only STORE runs, with no REFILL;
  - then DONE.
- `cfg_n_tiles`=0:
  - `layer_done` the cycle after acceptance;
  - no fetch or store requests at all.
- Assert `abort`, then separately `rst`, during STORE:
  - next cycle (abort) or immediately (rst) all requests and `core_stall_n` are 0, and `cfg_ready`=1;
  - stray `out_store_ack` afterwards has no effect;
  - a new config is accepted normally.
- Spurious `cfg_valid`, acks and update pulses in the wrong states:
  - no state change and no register change.

Source files
------------

// File: rtl/smac_layer_seq.sv
// Layer sequencer for the SMAC control unit: takes one layer configuration, gates the
// core with core_stall_n, and runs the fetch/store handshakes for every output tile.
module smac_layer_seq #(
   parameter int Pa  = 8,
   parameter int Pw  = 8,
   parameter int MNO = 288,
   parameter int MNV = 50176,
   parameter int TW  = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        abort,
   input  logic                        cfg_valid,
   output logic                        cfg_ready,
   input  logic [$clog2(MNO)-1:0]      cfg_max_done,
   input  logic [$clog2(Pa*Pw)-1:0]    cfg_max_quant,
   input  logic [2:0]                  cfg_max_out,
   input  logic [2:0]                  cfg_max_relu,
   input  logic [2:0]                  cfg_max_fil_group,
   input  logic [$clog2(MNV)-1:0]      cfg_max_in_vol,
   input  logic                        cfg_par_sel_Pa,
   input  logic [1:0]                  cfg_par_sel_Pw,
   input  logic [TW-1:0]               cfg_n_tiles,
   output logic [$clog2(MNO)-1:0]      max_val_cnt_done,
   output logic [$clog2(Pa*Pw)-1:0]    max_val_cnt_quant,
   output logic [2:0]                  max_val_cnt_out,
   output logic [2:0]                  max_val_cnt_relu,
   output logic [2:0]                  max_val_fil_group,
   output logic [$clog2(MNV)-1:0]      max_val_in_vol,
   output logic                        par_sel_Pa,
   output logic [1:0]                  par_sel_Pw,
   output logic                        core_stall_n,
   input  logic                        update_in,
   input  logic                        update_out,
   output logic                        act_fetch_req,
   input  logic                        act_fetch_ack,
   output logic                        out_store_req,
   input  logic                        out_store_ack,
   output logic [TW-1:0]               tile_idx,
   output logic                        busy,
   output logic                        layer_done
);

   localparam int DW = $clog2(MNO);
   localparam int QW = $clog2(Pa*Pw);
   localparam int VW = $clog2(MNV);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_COMPUTE, S_REFILL, S_STORE, S_DONE
   } state_t;

   state_t          state_reg, state_next;
   logic [TW-1:0]   tile_idx_reg, n_tiles_reg;
   logic [DW-1:0]   max_done_reg;
   logic [QW-1:0]   max_quant_reg;
   logic [2:0]      max_out_reg, max_relu_reg, max_fil_group_reg;
   logic [VW-1:0]   max_in_vol_reg;
   logic            par_sel_pa_reg;
   logic [1:0]      par_sel_pw_reg;
   logic            last_tile, cfg_accept, tile_advance;

   // Compared before the increment so the index stops at n_tiles-1 and never wraps.
   assign last_tile    = (tile_idx_reg == n_tiles_reg - TW'(1));
   assign cfg_accept   = (state_reg == S_IDLE) && cfg_valid && !abort;
   assign tile_advance = (state_reg == S_STORE) && out_store_ack && !last_tile && !abort;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         S_IDLE: begin
            if (cfg_valid) begin
               state_next = (cfg_n_tiles == '0) ? S_DONE : S_FETCH;
            end
         end
         S_FETCH, S_REFILL: begin
            if (act_fetch_ack) begin
               state_next = S_COMPUTE;
            end
         end
         S_COMPUTE: begin
            // A simultaneous update_in is absorbed by the next tile's FETCH.
            if (update_out) begin
               state_next = S_STORE;
            end else if (update_in) begin
               state_next = S_REFILL;
            end
         end
         S_STORE: begin
            if (out_store_ack) begin
               state_next = last_tile ? S_DONE : S_FETCH;
            end
         end
         S_DONE: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
      if (abort) begin
         state_next = S_IDLE;
      end
   end

   always_comb begin
      cfg_ready     = 1'b0;
      act_fetch_req = 1'b0;
      out_store_req = 1'b0;
      core_stall_n  = 1'b0;
      layer_done    = 1'b0;
      busy          = (state_reg != S_IDLE);
      unique case (state_reg)
         S_IDLE:             cfg_ready     = 1'b1;
         S_FETCH, S_REFILL:  act_fetch_req = 1'b1;
         S_COMPUTE:          core_stall_n  = 1'b1;
         S_STORE:            out_store_req = 1'b1;
         S_DONE:             layer_done    = 1'b1;
         default:            cfg_ready     = 1'b0;
      endcase
   end

   // Configuration survives abort; only reset clears it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         max_done_reg      <= '0;
         max_quant_reg     <= '0;
         max_out_reg       <= '0;
         max_relu_reg      <= '0;
         max_fil_group_reg <= '0;
         max_in_vol_reg    <= '0;
         par_sel_pa_reg    <= 1'b0;
         par_sel_pw_reg    <= '0;
         n_tiles_reg       <= '0;
      end else if (cfg_accept) begin
         max_done_reg      <= cfg_max_done;
         max_quant_reg     <= cfg_max_quant;
         max_out_reg       <= cfg_max_out;
         max_relu_reg      <= cfg_max_relu;
         max_fil_group_reg <= cfg_max_fil_group;
         max_in_vol_reg    <= cfg_max_in_vol;
         par_sel_pa_reg    <= cfg_par_sel_Pa;
         par_sel_pw_reg    <= cfg_par_sel_Pw;
         n_tiles_reg       <= cfg_n_tiles;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tile_idx_reg <= '0;
      end else if (cfg_accept) begin
         tile_idx_reg <= '0;
      end else if (tile_advance) begin
         tile_idx_reg <= tile_idx_reg + TW'(1);
      end
   end

   assign max_val_cnt_done  = max_done_reg;
   assign max_val_cnt_quant = max_quant_reg;
   assign max_val_cnt_out   = max_out_reg;
   assign max_val_cnt_relu  = max_relu_reg;
   assign max_val_fil_group = max_fil_group_reg;
   assign max_val_in_vol    = max_in_vol_reg;
   assign par_sel_Pa        = par_sel_pa_reg;
   assign par_sel_Pw        = par_sel_pw_reg;
   assign tile_idx          = tile_idx_reg;

endmodule
